// File: rtl/wrr_ingress.sv
// wrr_ingress: single-entry holding stage in front of a set of per-priority
// WRR FIFOs. A packet is forwarded only while its target queue has credit;
// credits are returned by the downstream pop strobe.
module wrr_ingress #(
  parameter int DATAPACK_BIT = 1024,
  parameter int QUEUE_BIT    = 8,
  parameter int PRIORITY_BIT = 3,
  parameter int DEPTH        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic [PRIORITY_BIT-1:0] in_prior,
  input  logic [DATAPACK_BIT-1:0] in_data,
  output logic                    in_ready,
  input  logic                    deq_vld,
  input  logic [PRIORITY_BIT-1:0] deq_prior,
  output logic                    data_vld,
  output logic [PRIORITY_BIT-1:0] prior,
  output logic [DATAPACK_BIT-1:0] Queue,
  output logic [QUEUE_BIT-1:0]    queue_full,
  output logic                    credit_err,
  output logic [15:0]             stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    EMPTY,
    LOADED
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    rdy_en;
  logic [PRIORITY_BIT-1:0] hold_prior;
  logic [DATAPACK_BIT-1:0] hold_data;
  logic [CW-1:0]           credit [QUEUE_BIT];

  logic                    hold_credit_ok;
  logic                    issue;
  logic                    accept;
  logic                    deq_ok;
  logic [QUEUE_BIT-1:0]    inc_vec;
  logic [QUEUE_BIT-1:0]    dec_vec;
  logic [QUEUE_BIT-1:0]    at_depth;

  // Credit lookup for the held packet and per-queue increment/decrement strobes
  always_comb begin
    hold_credit_ok = 1'b0;
    deq_ok         = deq_vld && (32'(deq_prior) < 32'(QUEUE_BIT));
    issue          = 1'b0;
    inc_vec        = '0;
    dec_vec        = '0;
    at_depth       = '0;
    queue_full     = '0;
    for (int unsigned i = 0; i < QUEUE_BIT; i++) begin
      if (32'(hold_prior) == i) begin
        hold_credit_ok = (credit[i] != '0);
      end
    end
    issue = (state == LOADED) && hold_credit_ok;
    for (int unsigned i = 0; i < QUEUE_BIT; i++) begin
      inc_vec[i]    = deq_ok && (32'(deq_prior) == i);
      dec_vec[i]    = issue && (32'(hold_prior) == i);
      at_depth[i]   = (credit[i] == CW'(DEPTH));
      queue_full[i] = (credit[i] == '0);
    end
  end

  // Upstream handshake; a slot frees up in the same cycle the held packet issues
  always_comb begin
    in_ready = rdy_en && ((state == EMPTY) || issue);
    accept   = in_vld && in_ready;
  end

  // Holding-register next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (accept)           state_nxt = LOADED;
      LOADED:  if (issue && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register, ready enable and holding register capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rdy_en     <= 1'b0;
      hold_prior <= '0;
      hold_data  <= '0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (accept) begin
        hold_prior <= in_prior;
        hold_data  <= in_data;
      end
    end
  end

  // Write strobe to the WRR FIFO; payload registers hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld <= 1'b0;
      prior    <= '0;
      Queue    <= '0;
    end else begin
      data_vld <= issue;
      if (issue) begin
        prior <= hold_prior;
        Queue <= hold_data;
      end
    end
  end

  // Credit counters: a simultaneous issue and pop on one queue cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QUEUE_BIT; i++) begin
        credit[i] <= CW'(DEPTH);
      end
    end else begin
      for (int unsigned i = 0; i < QUEUE_BIT; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          if (!at_depth[i]) credit[i] <= credit[i] + CW'(1);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          credit[i] <= credit[i] - CW'(1);
        end
      end
    end
  end

  // Sticky error on credit overflow or an out-of-range pop index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err <= 1'b0;
    end else if ((deq_vld && !deq_ok) || (|(inc_vec & ~dec_vec & at_depth))) begin
      credit_err <= 1'b1;
    end
  end

  // Saturating count of cycles the held packet waits for credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == LOADED) && !issue && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wrr_ingress.sv
// Testbench for wrr_ingress: directed scenarios followed by random traffic,
// checked against a transaction-level model with an output scoreboard.
module tb_wrr_ingress;

  localparam int DW    = 1024;
  localparam int QN    = 8;
  localparam int PW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic [PW-1:0] in_prior = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          deq_vld = 1'b0;
  logic [PW-1:0] deq_prior = '0;
  logic          data_vld;
  logic [PW-1:0] prior;
  logic [DW-1:0] Queue;
  logic [QN-1:0] queue_full;
  logic          credit_err;
  logic [15:0]   stall_cnt;

  wrr_ingress #(
    .DATAPACK_BIT(DW),
    .QUEUE_BIT   (QN),
    .PRIORITY_BIT(PW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_prior  (in_prior),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .deq_vld   (deq_vld),
    .deq_prior (deq_prior),
    .data_vld  (data_vld),
    .prior     (prior),
    .Queue     (Queue),
    .queue_full(queue_full),
    .credit_err(credit_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] p;
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: one optional waiting packet, integer credit per queue
  bit            m_held;
  logic [PW-1:0] m_hp;
  logic [DW-1:0] m_hd;
  int            m_cr [QN];
  bit            m_err;
  int            m_stall;
  bit            m_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_held  = 0;
    m_hp    = '0;
    m_hd    = '0;
    m_err   = 0;
    m_stall = 0;
    m_rdy   = 0;
    for (int q = 0; q < QN; q++) m_cr[q] = DEPTH;
    sb.delete();
  endtask

  // Hold reset for n cycles, then release with the given upstream request presented
  task automatic do_reset(input int n, input bit v, input logic [PW-1:0] p, input logic [DW-1:0] d);
    @(negedge clk);
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    deq_vld = 1'b0;
    #1;
    model_reset();
    check("rst_data_vld", 32'(data_vld), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_queue_full", 32'(queue_full), 0);
    check("rst_credit_err", 32'(credit_err), 0);
    check("rst_prior", 32'(prior), 0);
    check("rst_queue_zero", 32'(Queue == '0), 1);
    repeat (n) @(negedge clk);
    rst_n    = 1'b1;
    in_vld   = v;
    in_prior = p;
    in_data  = d;
    #1;
    check("release_in_ready", 32'(in_ready), 0);
    m_rdy = 1;
  endtask

  // One clock cycle: drive inputs, compare state outputs, advance the model
  task automatic step(input bit v, input logic [PW-1:0] p, input logic [DW-1:0] d,
                      input bit dq, input logic [PW-1:0] dp);
    bit            iss;
    bit            rdy;
    int            c;
    logic [QN-1:0] qf;
    @(negedge clk);
    in_vld    = v;
    in_prior  = p;
    in_data   = d;
    deq_vld   = dq;
    deq_prior = dp;
    #1;
    iss = m_held && (m_cr[m_hp] > 0);
    rdy = m_rdy && (!m_held || iss);
    for (int q = 0; q < QN; q++) qf[q] = (m_cr[q] == 0);
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("queue_full", 32'(queue_full), 32'(qf));
    check("credit_err", 32'(credit_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));

    if (m_held && !iss && m_stall < 16'hFFFF) m_stall++;
    if (dq && int'(dp) >= QN) m_err = 1;
    for (int q = 0; q < QN; q++) begin
      c = m_cr[q];
      if (iss && int'(m_hp) == q) c--;
      if (dq && int'(dp) == q) c++;
      if (c > DEPTH) begin
        c     = DEPTH;
        m_err = 1;
      end
      m_cr[q] = c;
    end
    if (iss) sb.push_back('{p: m_hp, d: m_hd, due: cyc + 1});
    if (v && rdy) begin
      m_held = 1;
      m_hp   = p;
      m_hd   = d;
    end else if (iss) begin
      m_held = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0, 0, '0);
  endtask

  // Output monitor: every write strobe must match the oldest expected issue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (data_vld) begin
        if (sb.size() == 0) begin
          check("spurious_data_vld", 32'(data_vld), 0);
        end else begin
          e = sb.pop_front();
          check("out_prior", 32'(prior), 32'(e.p));
          check("out_queue_lo", Queue[31:0], e.d[31:0]);
          check("out_queue_eq", 32'(Queue == e.d), 1);
          check("out_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_data_vld", 32'(data_vld), 1);
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    model_reset();

    // First packet after reset release: accepted on the second edge
    d = '0;
    d[7:0] = 8'hA5;
    do_reset(3, 1, 3'd3, d);
    step(1, 3'd3, d, 0, '0);
    idle(4);

    // Nine packets to queue 0 with no pops: ninth waits until one credit returns
    for (int i = 0; i < 9; i++) step(1, 3'd0, rnd_data(), 0, '0);
    idle(5);
    step(0, '0, '0, 1, 3'd0);
    idle(3);

    // Queue 2 exhausted with a packet waiting; pop and a new request together
    for (int i = 0; i < 9; i++) step(1, 3'd2, rnd_data(), 0, '0);
    idle(3);
    d = rnd_data();
    step(1, 3'd4, d, 1, 3'd2);
    step(1, 3'd4, d, 0, '0);
    idle(4);

    // Queue 5: issue and pop landing in the same cycle
    for (int i = 0; i < 4; i++) step(1, 3'd5, rnd_data(), 0, '0);
    for (int i = 0; i < 4; i++) step(1, 3'd5, rnd_data(), 1, 3'd5);
    idle(3);

    // Pop to a queue already at full credit: sticky error
    step(0, '0, '0, 1, 3'd1);
    idle(4);

    // Reset while a packet is stalled on queue 0
    step(1, 3'd0, rnd_data(), 0, '0);
    idle(4);
    do_reset(2, 0, '0, '0);
    idle(6);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset($urandom_range(1, 3), 0, '0, '0);
      end else begin
        step($urandom_range(0, 9) < 7, PW'($urandom_range(0, QN - 1)), rnd_data(),
             $urandom_range(0, 1) == 1, PW'($urandom_range(0, QN - 1)));
      end
    end
    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wrr_ingress.md
WRR_INGRESS -- requirements
Module: wrr_ingress

Interface
REQ-001 SHALL have parameter DATAPACK_BIT, default 1024, packet width.
REQ-002 SHALL have parameter QUEUE_BIT, default 8, number of priority queues.
REQ-003 SHALL have parameter PRIORITY_BIT, default 3, priority index width.
REQ-004 SHALL have parameter DEPTH, default 8, entries per downstream priority FIFO.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_vld  input  1  upstream packet valid.
REQ-009 in_prior  input  PRIORITY_BIT  upstream packet priority.
REQ-010 in_data  input  DATAPACK_BIT  upstream packet payload.
REQ-011 in_ready  output  1  block accepts packet this cycle.
REQ-012 deq_vld  input  1  downstream FIFO popped one entry this cycle.
REQ-013 deq_prior  input  PRIORITY_BIT  queue index of that pop.
REQ-014 data_vld  output  1  write strobe to the WRR FIFO.
REQ-015 prior  output  PRIORITY_BIT  target queue of the write.
REQ-016 Queue  output  DATAPACK_BIT  write payload.
REQ-017 queue_full  output  QUEUE_BIT  bit i = 1 when credit[i] == 0.
REQ-018 credit_err  output  1  sticky credit overflow flag.
REQ-019 stall_cnt  output  16  saturating count of blocked cycles.

Function
REQ-020 SHALL keep one credit counter per queue, width $clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-021 SHALL hold one packet in a holding register with FSM states EMPTY and LOADED.
REQ-022 Handshake: accept = in_vld && in_ready; in_data/in_prior SHALL be captured on the accept edge; in_vld SHALL NOT be required to hold after accept.
REQ-023 issue = LOADED && credit[hold_prior] != 0.
REQ-024 in_ready = rdy_en && (EMPTY || issue), combinational; accept and issue in the same cycle SHALL reload the holding register (stay LOADED).
REQ-025 rdy_en SHALL be a register cleared by reset and set on the first clk edge after rst_n deasserts.
REQ-026 Transitions: EMPTY->LOADED on accept; LOADED->EMPTY on issue without accept; LOADED->LOADED otherwise.
REQ-027 On issue, data_vld SHALL be 1 for exactly the following cycle, with prior/Queue equal to the issued packet; data_vld SHALL be 0 otherwise; prior/Queue hold last values.
REQ-028 Latency: packet accepted at edge k with credit available SHALL appear on data_vld in the cycle following edge k+1.
REQ-029 Packets SHALL be issued in acceptance order; no bypass of a blocked head packet.
REQ-030 On issue, credit[hold_prior] SHALL decrement by 1; on deq_vld, credit[deq_prior] SHALL increment by 1.
REQ-031 Issue and deq_vld to the same queue in one cycle SHALL leave that credit unchanged.
REQ-032 deq_vld to a queue with credit == DEPTH SHALL leave credit at DEPTH and set credit_err, which stays 1 until reset.
REQ-033 deq_vld with deq_prior >= QUEUE_BIT SHALL be ignored and SHALL set credit_err.
REQ-034 stall_cnt SHALL increment each cycle LOADED && !issue, saturating at 16'hFFFF.
REQ-035 data_vld SHALL never be asserted for a queue whose credit is 0.

Reset
REQ-036 rst_n low SHALL immediately force: FSM EMPTY, rdy_en 0, in_ready 0, data_vld 0, prior 0, Queue 0, all credits DEPTH, queue_full 0, credit_err 0, stall_cnt 0.
REQ-037 Reset mid-operation SHALL discard the held packet; no data_vld SHALL follow reset release without a new accept.

Verification
REQ-038 Reset release, in_vld=1, in_prior=3, in_data=0xA5 -> in_ready 0 in first cycle, accept on 2nd edge, data_vld=1/prior=3/Queue=0xA5 one cycle after the next edge; credit[3]=7.
REQ-039 Nine back-to-back packets to prior 0, no deq -> eight data_vld pulses, queue_full[0]=1, ninth held, in_ready 0, stall_cnt increments each cycle; one deq_vld prior 0 -> ninth issued next cycle.
REQ-040 credit[2]=0 with packet held, deq_vld prior 2 and new in_vld same cycle -> held packet issues, new packet accepted, credit[2] stays 0 after issue.
REQ-041 Issue to prior 5 and deq_vld prior 5 same cycle at credit 4 -> credit[5] remains 4.
REQ-042 deq_vld prior 1 with credit[1]=8 -> credit[1] stays 8, credit_err=1, persists until rst_n low.
REQ-043 rst_n pulsed low while LOADED and stalled -> data_vld 0, stall_cnt 0, all queue_full 0, no issue after release.
